cdb_arbiter: RTL

Shares the two common data buses (CDB_0, CDB_1) among NUM_FU functional units of the two-thread out-of-order core.
- Each FU hands over one completed result through a valid/ready handshake into a one-entry holding register.
- A round-robin scheduler grants at most two held results per cycle onto CDB_0/CDB_1.
- CDB_0/CDB_1 feed the PRF (value write and ready bit) and the reservation stations.
- Per-thread mispredict squashes in-flight results.

---
 rtl/sys_defs.sv | 23 ++
 rtl/cdb_arbiter_if.sv | 23 ++
 rtl/rr_pick2.sv | 41 ++++
 rtl/cdb_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared core definitions: physical register file geometry and the common data bus record.
package sys_defs;

   localparam int PR_SIZE   = 64;
   localparam int PR_BITS   = $clog2(PR_SIZE);
   localparam int CDB_WIDTH = 2;

   // The highest physical register is the hardwired zero register; writes to it are discarded.
   localparam logic [PR_BITS-1:0] ZERO_PRN = PR_BITS'(PR_SIZE - 1);

   typedef struct packed {
      logic [PR_BITS-1:0] PRN;
      logic               valid;
      logic [63:0]        FU_result;
   } CDB;

   function automatic logic is_squashed(input logic thread_id,
                                        input logic mispredict_thread_0,
                                        input logic mispredict_thread_1);
      return thread_id ? mispredict_thread_1 : mispredict_thread_0;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result handshake from the functional units and the two broadcast buses back out.
interface cdb_arbiter_if #(parameter int NUM_FU = 6);
   import sys_defs::*;

   logic [NUM_FU-1:0]  fu_valid;
   logic [NUM_FU-1:0]  fu_thread_id;
   logic [PR_BITS-1:0] fu_PRN    [NUM_FU];
   logic [63:0]        fu_result [NUM_FU];
   logic [NUM_FU-1:0]  fu_ready;
   CDB                 CDB_0;
   CDB                 CDB_1;

   modport master (
      output fu_valid, fu_thread_id, fu_PRN, fu_result,
      input  fu_ready, CDB_0, CDB_1
   );

   modport slave (
      input  fu_valid, fu_thread_id, fu_PRN, fu_result,
      output fu_ready, CDB_0, CDB_1
   );

endinterface

// File: rtl/rr_pick2.sv
// Round-robin selector: the first two set bits of an eligible vector, scanning upward from ptr
// and wrapping. Purely combinational.
module rr_pick2 #(
   parameter int NUM_FU  = 6,
   parameter int FU_BITS = $clog2(NUM_FU)
) (
   input  logic [NUM_FU-1:0]  eligible,
   input  logic [FU_BITS-1:0] ptr,
   output logic [NUM_FU-1:0]  grant_0,
   output logic [NUM_FU-1:0]  grant_1,
   output logic               valid_0,
   output logic               valid_1
);

   always_comb begin
      int                 scan;
      logic [FU_BITS-1:0] idx;
      // NOTE: every output gets a default before the loop so no path can infer a latch.
      grant_0 = '0;
      grant_1 = '0;
      valid_0 = 1'b0;
      valid_1 = 1'b0;
      scan    = 0;
      idx     = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         scan = int'(ptr) + k;
         if (scan >= NUM_FU) scan = scan - NUM_FU;
         idx = FU_BITS'(scan);
         if (eligible[idx]) begin
            if (!valid_0) begin
               grant_0[idx] = 1'b1;
               valid_0      = 1'b1;
            end else if (!valid_1) begin
               grant_1[idx] = 1'b1;
               valid_1      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Collects one completed result per functional unit and broadcasts up to two per cycle on
// CDB_0/CDB_1 in round-robin order, dropping results of a mispredicted thread.
module cdb_arbiter
   import sys_defs::*;
#(
   parameter int NUM_FU  = 6,
   parameter int FU_BITS = $clog2(NUM_FU)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               mispredict_thread_0,
   input  logic               mispredict_thread_1,
   cdb_arbiter_if.slave       bus,
   output logic [FU_BITS:0]   pending_count
);

   logic [NUM_FU-1:0]    held_valid;
   logic [NUM_FU-1:0]    held_thread;
   logic [PR_BITS-1:0]   held_prn   [NUM_FU];
   logic [63:0]          held_value [NUM_FU];
   logic [FU_BITS-1:0]   rr_ptr;

   logic [NUM_FU-1:0]    squashed;
   logic [NUM_FU-1:0]    eligible;
   logic [NUM_FU-1:0]    grant_0;
   logic [NUM_FU-1:0]    grant_1;
   logic [NUM_FU-1:0]    granted;
   logic [NUM_FU-1:0]    ready;
   logic [NUM_FU-1:0]    capture;
   logic [NUM_FU-1:0]    held_valid_next;
   logic [CDB_WIDTH-1:0] grant_valid;
   logic [FU_BITS-1:0]   last_idx;
   logic [FU_BITS-1:0]   rr_ptr_next;
   logic [FU_BITS:0]     pending_next;
   CDB                   cdb_0;
   CDB                   cdb_1;

   always_comb begin
      squashed = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         squashed[i] = held_valid[i] &
                       is_squashed(held_thread[i], mispredict_thread_0, mispredict_thread_1);
      end
   end

   assign eligible = held_valid & ~squashed;

   rr_pick2 #(.NUM_FU(NUM_FU), .FU_BITS(FU_BITS)) u_pick (
      .eligible (eligible),
      .ptr      (rr_ptr),
      .grant_0  (grant_0),
      .grant_1  (grant_1),
      .valid_0  (grant_valid[0]),
      .valid_1  (grant_valid[1])
   );

   assign granted = grant_0 | grant_1;

   // An entry leaving this cycle frees its slot, so a busy FU can stream one result per cycle.
   assign ready        = ~held_valid | granted | squashed;
   assign bus.fu_ready = ready;

   always_comb begin
      capture         = '0;
      held_valid_next = held_valid;
      pending_next    = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         capture[i] = bus.fu_valid[i] & ready[i] &
                      !is_squashed(bus.fu_thread_id[i], mispredict_thread_0, mispredict_thread_1) &
                      (bus.fu_PRN[i] != ZERO_PRN);
         if (capture[i])                    held_valid_next[i] = 1'b1;
         else if (granted[i] | squashed[i]) held_valid_next[i] = 1'b0;
         pending_next = pending_next + (FU_BITS+1)'(held_valid_next[i]);
      end
   end

   always_comb begin
      last_idx = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (grant_valid[1] ? grant_1[i] : grant_0[i]) last_idx = FU_BITS'(i);
      end
      rr_ptr_next = (last_idx == FU_BITS'(NUM_FU - 1)) ? '0 : last_idx + FU_BITS'(1);
   end

   always_comb begin
      cdb_0 = '0;
      cdb_1 = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (grant_0[i]) begin
            cdb_0.PRN       = held_prn[i];
            cdb_0.valid     = 1'b1;
            cdb_0.FU_result = held_value[i];
         end
         if (grant_1[i]) begin
            cdb_1.PRN       = held_prn[i];
            cdb_1.valid     = 1'b1;
            cdb_1.FU_result = held_value[i];
         end
      end
   end

   assign bus.CDB_0 = cdb_0;
   assign bus.CDB_1 = cdb_1;

   // NOTE: state registers update with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         held_valid    <= '0;
         rr_ptr        <= '0;
         pending_count <= '0;
      end else begin
         held_valid    <= held_valid_next;
         pending_count <= pending_next;
         if (grant_valid[0]) rr_ptr <= rr_ptr_next;
      end
   end

   // NOTE: payload storage has no reset; it is only observed while its held_valid bit is set.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (capture[i]) begin
            held_thread[i] <= bus.fu_thread_id[i];
            held_prn[i]    <= bus.fu_PRN[i];
            held_value[i]  <= bus.fu_result[i];
         end
      end
   end

endmodule
